// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Byte-addressable, little-endian data memory for a single-cycle RV32I
// datapath. Loads are combinational. Stores, misaligned-access fault capture
// and the committed-store counter update on the rising clock edge.
//
// Parameters
//   WORDS          memory depth in 32-bit words (power of two, >= 4)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (memory contents retained)
//   Address        byte address from the ALU
//   DataWr         store data (rs2)
//   DMWr           store enable
//   DMRd           load enable
//   DMCtrl         access type, RV32I funct3 (B/H/W/BU/HU)
//   FaultClr       clears the sticky misalignment flag
//   DataRd         combinational load result (0 when not a legal aligned load)
//   MisalignFault  sticky misaligned-access flag
//   FaultAddr      address of the first faulting access
//   StoreCount     number of committed stores, wrapping at 16 bits
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic        DMRd,
  input  logic [2:0]  DMCtrl,
  input  logic        FaultClr,
  output logic [31:0] DataRd,
  output logic        MisalignFault,
  output logic [31:0] FaultAddr,
  output logic [15:0] StoreCount
);

  localparam int unsigned IW = $clog2(WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Storage array; never reset, contents survive rst.
  logic [31:0] mem_q [WORDS];

  logic [IW-1:0] word_idx_s;
  logic [31:0]   word_rd_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic          ld_legal_s;
  logic          st_legal_s;
  logic          misaligned_s;
  logic          fault_ev_s;
  logic          store_commit_s;
  logic [3:0]    byte_en_s;
  logic [31:0]   wr_data_s;
  logic [31:0]   rd_data_s;
  logic [31:0]   data_rd_s;

  logic          fault_d,       fault_q;
  logic [31:0]   fault_addr_d,  fault_addr_q;
  logic [15:0]   store_count_d, store_count_q;

  // Address bits above the index are dropped, so out-of-range addresses alias.
  assign word_idx_s = Address[IW+1:2];
  assign word_rd_s  = mem_q[word_idx_s];
  assign byte_s     = word_rd_s[{Address[1:0], 3'b000} +: 8];
  assign half_s     = word_rd_s[{Address[1], 4'b0000} +: 16];

  // Decode access type: legality per direction and alignment by access size.
  // BU/HU exist only as loads; a store with those codes is illegal.
  always_comb begin
    ld_legal_s   = 1'b0;
    st_legal_s   = 1'b0;
    misaligned_s = 1'b0;
    case (DMCtrl)
      F3_B: begin
        ld_legal_s = 1'b1;
        st_legal_s = 1'b1;
      end
      F3_H: begin
        ld_legal_s   = 1'b1;
        st_legal_s   = 1'b1;
        misaligned_s = Address[0];
      end
      F3_W: begin
        ld_legal_s   = 1'b1;
        st_legal_s   = 1'b1;
        misaligned_s = (Address[1:0] != 2'b00);
      end
      F3_BU: begin
        ld_legal_s = 1'b1;
      end
      F3_HU: begin
        ld_legal_s   = 1'b1;
        misaligned_s = Address[0];
      end
      default: begin
        ld_legal_s   = 1'b0;
        st_legal_s   = 1'b0;
        misaligned_s = 1'b0;
      end
    endcase
  end

  // A fault needs a legal request in some direction; illegal codes never fault.
  assign fault_ev_s     = misaligned_s & ((DMRd & ld_legal_s) | (DMWr & st_legal_s));
  assign store_commit_s = DMWr & st_legal_s & ~misaligned_s & ~rst;

  // Load path: lane extraction with sign/zero extension, gated to zero
  // unless this is a legal, aligned, enabled load.
  always_comb begin
    rd_data_s = 32'd0;
    case (DMCtrl)
      F3_B:    rd_data_s = {{24{byte_s[7]}}, byte_s};
      F3_BU:   rd_data_s = {24'd0, byte_s};
      F3_H:    rd_data_s = {{16{half_s[15]}}, half_s};
      F3_HU:   rd_data_s = {16'd0, half_s};
      F3_W:    rd_data_s = word_rd_s;
      default: rd_data_s = 32'd0;
    endcase
    if (DMRd && ld_legal_s && !misaligned_s) begin
      data_rd_s = rd_data_s;
    end else begin
      data_rd_s = 32'd0;
    end
  end

  // Store path: byte enables and lane-replicated write data.
  always_comb begin
    byte_en_s = 4'b0000;
    wr_data_s = DataWr;
    case (DMCtrl)
      F3_B: begin
        byte_en_s = 4'b0001 << Address[1:0];
        wr_data_s = {4{DataWr[7:0]}};
      end
      F3_H: begin
        if (Address[1]) begin
          byte_en_s = 4'b1100;
        end else begin
          byte_en_s = 4'b0011;
        end
        wr_data_s = {2{DataWr[15:0]}};
      end
      F3_W: begin
        byte_en_s = 4'b1111;
        wr_data_s = DataWr;
      end
      default: begin
        byte_en_s = 4'b0000;
        wr_data_s = DataWr;
      end
    endcase
  end

  // Byte-lane writes into the array; unwritten lanes keep their contents.
  always_ff @(posedge clk) begin
    if (store_commit_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  // Next-state for fault flag, fault address and store counter. A new fault
  // outranks FaultClr on the same edge and then records its own address.
  always_comb begin
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    store_count_d = store_count_q;
    if (fault_ev_s) begin
      fault_d = 1'b1;
      if (!fault_q || FaultClr) begin
        fault_addr_d = Address;
      end else begin
        fault_addr_d = fault_addr_q;
      end
    end else if (FaultClr) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
    if (store_commit_s) begin
      store_count_d = store_count_q + 16'd1;
    end else begin
      store_count_d = store_count_q;
    end
  end

  // Control/status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q       <= 1'b0;
      fault_addr_q  <= 32'd0;
      store_count_q <= 16'd0;
    end else begin
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      store_count_q <= store_count_d;
    end
  end

  assign DataRd        = data_rd_s;
  assign MisalignFault = fault_q;
  assign FaultAddr     = fault_addr_q;
  assign StoreCount    = store_count_q;

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Self-checking bench for data_memory (WORDS = 1024). A byte-array reference
// model tracks memory, the sticky fault and the store counter; each cycle the
// combinational load result is compared before the edge and the registered
// status after it. Directed steps are followed by randomized traffic and a
// counter wrap run.
// -----------------------------------------------------------------------------
module tb_data_memory;

  localparam int unsigned WORDS = 1024;
  localparam int unsigned BYTES = WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_wr;
  logic        dm_wr;
  logic        dm_rd;
  logic [2:0]  dm_ctrl;
  logic        fault_clr;
  logic [31:0] data_rd;
  logic        misalign_fault;
  logic [31:0] fault_addr;
  logic [15:0] store_count;

  data_memory #(.WORDS(WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .Address      (address),
    .DataWr       (data_wr),
    .DMWr         (dm_wr),
    .DMRd         (dm_rd),
    .DMCtrl       (dm_ctrl),
    .FaultClr     (fault_clr),
    .DataRd       (data_rd),
    .MisalignFault(misalign_fault),
    .FaultAddr    (fault_addr),
    .StoreCount   (store_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mem_m [BYTES];
  logic        flag_m;
  logic [31:0] faddr_m;
  logic [15:0] count_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Access size in bytes for a load (0 = illegal code)
  function automatic int ld_size(input logic [2:0] c);
    case (c)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Access size for a store (only B/H/W exist)
  function automatic int st_size(input logic [2:0] c);
    case (c)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_signed(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c, input bit rd);
    int n;
    int base;
    logic [31:0] v;
    n = ld_size(c);
    if (!rd || n == 0) return 32'd0;
    if ((a % n) != 0) return 32'd0;
    base = int'(a % BYTES);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_m[base + k]) << (8 * k));
    if (is_signed(c) && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_edge(input bit r, input logic [31:0] a, input logic [31:0] d,
                            input bit w, input bit rd, input logic [2:0] c, input bit clr);
    int ln;
    int sn;
    bit fault_ev;
    int base;
    if (r) begin
      flag_m  = 1'b0;
      faddr_m = 32'd0;
      count_m = 16'd0;
      return;
    end
    ln = ld_size(c);
    sn = st_size(c);
    fault_ev = (rd && ln != 0 && (a % ln) != 0) || (w && sn != 0 && (a % sn) != 0);
    if (fault_ev) begin
      if (!flag_m || clr) faddr_m = a;
      flag_m = 1'b1;
    end else if (clr) begin
      flag_m = 1'b0;
    end
    if (w && sn != 0 && (a % sn) == 0) begin
      base = int'(a % BYTES);
      for (int k = 0; k < sn; k++) mem_m[base + k] = d[8*k +: 8];
      count_m = count_m + 16'd1;
    end
  endtask

  // One clock cycle: drive, check the combinational load, clock, check status.
  task automatic do_cycle(input bit r, input logic [31:0] a, input logic [31:0] d,
                          input bit w, input bit rd, input logic [2:0] c,
                          input bit clr, input bit chk_en);
    rst = r; address = a; data_wr = d; dm_wr = w; dm_rd = rd; dm_ctrl = c; fault_clr = clr;
    #1;
    if (chk_en) chk("data_rd", data_rd, model_load(a, c, rd));
    @(posedge clk);
    model_edge(r, a, d, w, rd, c, clr);
    #1;
    if (chk_en) begin
      chk("fault", {31'd0, misalign_fault}, {31'd0, flag_m});
      chk("fault_addr", fault_addr, faddr_m);
      chk("store_count", {16'd0, store_count}, {16'd0, count_m});
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] cnt0;
    flag_m = 1'b0; faddr_m = 32'd0; count_m = 16'd0;
    rst = 1'b1; address = 32'd0; data_wr = 32'd0; dm_wr = 1'b0;
    dm_rd = 1'b0; dm_ctrl = 3'd0; fault_clr = 1'b0;

    // Reset with a store request pending: suppressed, status cleared
    do_cycle(1'b1, 32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    chk("reset_count", {16'd0, store_count}, 32'd0);
    chk("reset_fault", {31'd0, misalign_fault}, 32'd0);

    // Fill the whole array so every later load has a defined value
    for (int i = 0; i < int'(WORDS); i++)
      do_cycle(1'b0, 32'(i * 4), $urandom, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    chk("fill_count", {16'd0, store_count}, 32'(WORDS));

    // Word store with same-cycle load (pre-store contents), then load back
    cnt0 = count_m;
    do_cycle(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
    do_cycle(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    chk("lw_10", data_rd, 32'hDEAD_BEEF);
    chk("sw_count", {16'd0, store_count}, {16'd0, cnt0 + 16'd1});

    // Byte store into lane 3, then signed/unsigned byte and word loads
    do_cycle(1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    do_cycle(1'b0, 32'h23, 32'h1234_5680, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    do_cycle(1'b0, 32'h23, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    chk("lb_23", data_rd, 32'hFFFF_FF80);
    do_cycle(1'b0, 32'h23, 32'h0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
    chk("lbu_23", data_rd, 32'h0000_0080);
    do_cycle(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    chk("lw_20", data_rd, 32'h8000_0000);

    // Halfword store to upper lanes; lower lanes untouched (model-checked)
    do_cycle(1'b0, 32'h42, 32'h1234_F00D, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1);
    do_cycle(1'b0, 32'h42, 32'h0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
    chk("lh_42", data_rd, 32'hFFFF_F00D);
    do_cycle(1'b0, 32'h42, 32'h0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    chk("lhu_42", data_rd, 32'h0000_F00D);
    do_cycle(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);

    // Misalignment: capture, first-fault-wins, clear-vs-new-fault, clear
    cnt0 = count_m;
    do_cycle(1'b0, 32'h41, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1);
    chk("mis_flag", {31'd0, misalign_fault}, 32'd1);
    chk("mis_addr", fault_addr, 32'h41);
    chk("mis_count", {16'd0, store_count}, {16'd0, cnt0});
    do_cycle(1'b0, 32'h46, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    chk("lw_46_rd", data_rd, 32'd0);
    chk("lw_46_addr", fault_addr, 32'h41);
    do_cycle(1'b0, 32'h7, 32'h0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    chk("clr_new_flag", {31'd0, misalign_fault}, 32'd1);
    chk("clr_new_addr", fault_addr, 32'h7);
    do_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    chk("clr_flag", {31'd0, misalign_fault}, 32'd0);
    do_cycle(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);

    // Address aliasing above the array
    do_cycle(1'b0, 32'h1004, 32'hA5A5_A5A5, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    do_cycle(1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    chk("alias_4", data_rd, 32'hA5A5_A5A5);

    // Illegal code on a store: no write, no count, no fault
    cnt0 = count_m;
    do_cycle(1'b0, 32'h51, 32'hFFFF_FFFF, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1);
    chk("ill_count", {16'd0, store_count}, {16'd0, cnt0});
    do_cycle(1'b0, 32'h50, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);

    // Reset mid-sequence after a fault: status cleared, memory retained
    do_cycle(1'b0, 32'h33, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    do_cycle(1'b1, 32'h10, 32'h0BAD_0BAD, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    chk("rst_mid_flag", {31'd0, misalign_fault}, 32'd0);
    chk("rst_mid_addr", fault_addr, 32'd0);
    do_cycle(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    chk("rst_mid_mem", data_rd, 32'hDEAD_BEEF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & 32'h0000_00FF;
      do_cycle(($urandom_range(0, 49) == 0), ra, $urandom,
               ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), 1'b1);
    end

    // Counter wrap: commit stores until 0xFFFF, then one more
    while (count_m != 16'hFFFF)
      do_cycle(1'b0, 32'h200, 32'(count_m), 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    chk("count_ffff", {16'd0, store_count}, 32'h0000_FFFF);
    do_cycle(1'b0, 32'h204, 32'h0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
    chk("count_wrap", {16'd0, store_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
